// File: rtl/apu_pkg.sv
// Shared APU definitions: register select encoding and channel constants.
// Latency: n/a (package).
// Backpressure: n/a (package).
package apu_pkg;

  // Register select values on reg_sel
  typedef enum logic [1:0] {
    NRX1 = 2'd0,  // length load
    NRX2 = 2'd1,  // envelope
    NRX3 = 2'd2,  // frequency low byte
    NRX4 = 2'd3   // trigger / length enable / frequency high bits
  } apu_reg_e;

  localparam int         LEN_MAX   = 64;
  localparam logic [3:0] VOL_MAX   = 4'hF;
  localparam int         FREQ_BASE = 2048;

endpackage

// File: rtl/envelope_unit.sv
// Volume envelope: steps volume up/down once per env_period ticks, stops at 0/15.
// Latency: trigger and ticks update volume on the following clk.
// Backpressure: none; every trigger/tick is consumed (trigger wins over tick).
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   trigger            reload volume/counter from the NRx2 fields
//   tick               qualified 64 Hz envelope tick
//   init_vol, env_up,  NRx2 fields
//   env_period
//   volume             current envelope volume
module envelope_unit
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic       tick,
  input  logic [3:0] init_vol,
  input  logic       env_up,
  input  logic [2:0] env_period,
  output logic [3:0] volume
);

  logic [3:0] vol_q;
  logic [2:0] env_cnt;
  logic       env_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      vol_q      <= 4'd0;
      env_cnt    <= 3'd0;
      env_active <= 1'b0;
    end else if (trigger) begin
      vol_q      <= init_vol;
      env_cnt    <= env_period;
      env_active <= 1'b1;
    end else if (tick && (env_period != 3'd0) && env_active) begin
      // env_cnt of 0 can occur if the period was 0 at trigger and changed later;
      // treat it the same as an expiring count.
      if (env_cnt <= 3'd1) begin
        env_cnt <= env_period;
        if (env_up) begin
          if (vol_q != VOL_MAX) begin
            vol_q <= vol_q + 4'd1;
            if ((vol_q + 4'd1) == VOL_MAX) env_active <= 1'b0;
          end else begin
            env_active <= 1'b0;
          end
        end else begin
          if (vol_q != 4'd0) begin
            vol_q <= vol_q - 4'd1;
            if (vol_q == 4'd1) env_active <= 1'b0;
          end else begin
            env_active <= 1'b0;
          end
        end
      end else begin
        env_cnt <= env_cnt - 3'd1;
      end
    end
  end

  assign volume = vol_q;

endmodule

// File: rtl/square_sequencer.sv
// Square channel sequencer: CPU registers, frequency timer, length counter, envelope.
// Latency: register writes and ticks take effect on the next clk; next_step is a decode of the timer.
// Backpressure: none; CPU writes are always accepted and override same-cycle tick updates.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   slow_clk_en           M-cycle tick enable
//   cpu_en, reg_write     CPU write qualifier and strobe
//   length_tick, env_tick frame-sequencer pulses, qualified by slow_clk_en
//   reg_sel, wdata        register select (NRx1..NRx4) and write data
//   next_step             duty-step advance pulse (timer == 1)
//   playing, volume       channel active flag and envelope volume
//   dac_on                NRx2[7:3] != 0
module square_sequencer
  import apu_pkg::*;
#(
  parameter int FREQ_W = 11,
  parameter int LEN_W  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clk_en,
  input  logic       cpu_en,
  input  logic       length_tick,
  input  logic       env_tick,
  input  logic       reg_write,
  input  logic [1:0] reg_sel,
  input  logic [7:0] wdata,
  output logic       next_step,
  output logic       playing,
  output logic [3:0] volume,
  output logic       dac_on
);

  localparam logic [FREQ_W:0] FREQ_FULL = (FREQ_W+1)'(FREQ_BASE);
  localparam logic [LEN_W:0]  LEN_FULL  = (LEN_W+1)'(LEN_MAX);

  apu_reg_e sel;
  logic     cpu_wr, wr_nrx1, wr_nrx2, wr_nrx3, wr_nrx4, trigger;

  assign sel     = apu_reg_e'(reg_sel);
  assign cpu_wr  = cpu_en & reg_write;
  assign wr_nrx1 = cpu_wr && (sel == NRX1);
  assign wr_nrx2 = cpu_wr && (sel == NRX2);
  assign wr_nrx3 = cpu_wr && (sel == NRX3);
  assign wr_nrx4 = cpu_wr && (sel == NRX4);
  assign trigger = wr_nrx4 & wdata[7];

  // NRx2 envelope register
  logic [7:0] nrx2_q;

  always_ff @(posedge clk) begin
    if (reset)        nrx2_q <= 8'd0;
    else if (wr_nrx2) nrx2_q <= wdata;
  end

  assign dac_on = |nrx2_q[7:3];

  // Frequency register and timer
  logic [FREQ_W-1:0] freq_q, freq_trig, timer_q, reload_trig, reload_run;
  logic [FREQ_W:0]   diff_trig, diff_run;

  always_ff @(posedge clk) begin
    if (reset)        freq_q <= '0;
    else if (wr_nrx3) freq_q[7:0] <= wdata;
    else if (wr_nrx4) freq_q[FREQ_W-1:8] <= wdata[FREQ_W-9:0];
  end

  // A trigger reloads with the high bits carried in the same NRx4 write
  assign freq_trig   = {wdata[FREQ_W-9:0], freq_q[7:0]};
  assign diff_trig   = FREQ_FULL - {1'b0, freq_trig};
  assign diff_run    = FREQ_FULL - {1'b0, freq_q};
  assign reload_trig = diff_trig[FREQ_W-1:0];
  assign reload_run  = diff_run[FREQ_W-1:0];

  always_ff @(posedge clk) begin
    if (reset)                          timer_q <= '0;
    else if (trigger)                   timer_q <= reload_trig;
    else if (slow_clk_en) begin
      if (timer_q == FREQ_W'(1))        timer_q <= reload_run;
      else                              timer_q <= timer_q - FREQ_W'(1);
    end
  end

  assign next_step = (timer_q == FREQ_W'(1));

  // Length counter
  logic [LEN_W:0] len_cnt;
  logic           len_en_q, len_tick, len_expire;

  assign len_tick   = slow_clk_en & length_tick & len_en_q & (len_cnt != '0);
  assign len_expire = len_tick & (len_cnt == (LEN_W+1)'(1));

  always_ff @(posedge clk) begin
    if (reset)        len_en_q <= 1'b0;
    else if (wr_nrx4) len_en_q <= wdata[6];
  end

  always_ff @(posedge clk) begin
    if (reset)
      len_cnt <= '0;
    else if (wr_nrx1)
      len_cnt <= LEN_FULL - {1'b0, wdata[LEN_W-1:0]};
    else if (trigger) begin
      // A tick expiring the counter alongside the trigger still reloads to full
      if ((len_cnt == '0) || len_expire) len_cnt <= LEN_FULL;
    end else if (len_tick)
      len_cnt <= len_cnt - (LEN_W+1)'(1);
  end

  // Playing flag: DAC-off write beats trigger beats length expiry
  logic playing_q;

  always_ff @(posedge clk) begin
    if (reset)                               playing_q <= 1'b0;
    else if (wr_nrx2 && (wdata[7:3] == 5'd0)) playing_q <= 1'b0;
    else if (trigger)                        playing_q <= dac_on;
    else if (len_expire)                     playing_q <= 1'b0;
  end

  assign playing = playing_q;

  envelope_unit u_env (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .tick       (slow_clk_en & env_tick),
    .init_vol   (nrx2_q[7:4]),
    .env_up     (nrx2_q[3]),
    .env_period (nrx2_q[2:0]),
    .volume     (volume)
  );

endmodule
